// File: rtl/packet_filter_pkg.sv
// Shared arbiter definitions: FSM state encoding and the port-index width helper.
package packet_filter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    function automatic int unsigned port_idx_width(input int unsigned num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

endpackage

// File: rtl/egress_arbiter_rr_picker.sv
// Rotate-priority picker: first asserted request at or above ptr, wrapping; purely combinational.
module rr_picker
    import packet_filter_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int IW        = port_idx_width(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IW-1:0]        ptr,
    output logic [IW-1:0]        idx,
    output logic                 found
);

    int cand;

    // Scan offsets high to low so the smallest offset from ptr wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_PORTS) begin
                cand = cand - NUM_PORTS;
            end
            if (req[cand[IW-1:0]]) begin
                idx   = cand[IW-1:0];
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/egress_arbiter.sv
// Frame-locked round-robin mux of NUM_PORTS beat streams onto one egress; 1-cycle grant, then beats pass combinationally.
// egress_ready is forwarded only to the owner's req_ready; EGRESS_ARB_TIMEOUT_EN adds a stalled-frame abort.
module egress_arbiter
    import packet_filter_pkg::*;
#(
    parameter int NUM_PORTS         = 4,
    parameter int DATA_WIDTH        = 20,
    parameter int TIMEOUT_CTR_WIDTH = 3
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            req_valid,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_PORTS-1:0]            req_last,
    output logic [NUM_PORTS-1:0]            req_ready,
    output logic                            egress_valid,
    output logic [DATA_WIDTH-1:0]           egress_data,
    output logic                            egress_last,
    input  logic                            egress_ready,
    output logic [$clog2(NUM_PORTS)-1:0]    grant_id,
    output logic                            busy,
    output logic                            timeout
);

    localparam int IW = port_idx_width(NUM_PORTS);

    arb_state_t      state_q, state_d;
    logic [IW-1:0]   grant_id_q, grant_id_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   next_ptr;
    logic [IW-1:0]   pick_idx;
    logic            pick_found;
    logic [DATA_WIDTH-1:0] port_dat [NUM_PORTS];

`ifdef EGRESS_ARB_TIMEOUT_EN
    logic [TIMEOUT_CTR_WIDTH-1:0] stall_q, stall_d;
    logic                         timeout_q, timeout_d;
`endif

    rr_picker #(
        .NUM_PORTS (NUM_PORTS),
        .IW        (IW)
    ) u_picker (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            port_dat[p] = req_data[p*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign next_ptr = (grant_id_q == IW'(NUM_PORTS - 1)) ? '0 : grant_id_q + 1'b1;
    assign busy     = (state_q == ST_GRANT);
    assign grant_id = grant_id_q;

    // Owner's stream is wired straight through; everyone else sees req_ready low.
    always_comb begin
        req_ready    = '0;
        egress_valid = 1'b0;
        egress_data  = '0;
        egress_last  = 1'b0;
        if (state_q == ST_GRANT) begin
            egress_valid          = req_valid[grant_id_q];
            egress_data           = port_dat[grant_id_q];
            egress_last           = req_last[grant_id_q];
            req_ready[grant_id_q] = egress_ready;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
`ifdef EGRESS_ARB_TIMEOUT_EN
        stall_d    = '0;
        timeout_d  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_id_d = pick_idx;
                    state_d    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (egress_valid && egress_ready && egress_last) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = next_ptr;
                end
`ifdef EGRESS_ARB_TIMEOUT_EN
                // Owner went quiet mid-frame: abandon it once the counter saturates.
                if (!egress_valid) begin
                    stall_d = stall_q + 1'b1;
                    if (&stall_d) begin
                        timeout_d = 1'b1;
                        state_d   = ST_IDLE;
                        rr_ptr_d  = next_ptr;
                        stall_d   = '0;
                    end
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
`ifdef EGRESS_ARB_TIMEOUT_EN
            stall_q    <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
`ifdef EGRESS_ARB_TIMEOUT_EN
            stall_q    <= stall_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

`ifdef EGRESS_ARB_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    // No abort path in this build; the width parameter only matters with the counter present.
    assign timeout = 1'b0 && (TIMEOUT_CTR_WIDTH > 0);
`endif

endmodule

// File: tb/tb_egress_arbiter.sv
// Randomized and directed bench for egress_arbiter against a frame-level reference model.
module tb_egress_arbiter;

    localparam int N  = 4;
    localparam int DW = 20;
    localparam int TW = 3;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_last = '0;
    logic [DW-1:0]   bus_d [N];
    logic [N*DW-1:0] req_data;
    logic            egress_ready = 1'b0;

    logic [N-1:0]    req_ready;
    logic            egress_valid;
    logic [DW-1:0]   egress_data;
    logic            egress_last;
    logic [1:0]      grant_id;
    logic            busy;
    logic            timeout;

    egress_arbiter #(
        .NUM_PORTS         (N),
        .DATA_WIDTH        (DW),
        .TIMEOUT_CTR_WIDTH (TW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .egress_valid (egress_valid),
        .egress_data  (egress_data),
        .egress_last  (egress_last),
        .egress_ready (egress_ready),
        .grant_id     (grant_id),
        .busy         (busy),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int p = 0; p < N; p++) begin
            req_data[p*DW +: DW] = bus_d[p];
        end
    end

    // Per-port source queues of pending beats: {last, data}.
    logic [DW:0] sq [N][$];
    logic [N-1:0] mask = '0;
    bit   force_v = 1'b1;
    bit   erdy_fixed = 1'b1;
    logic erdy_val = 1'b1;

    // Reference model: who owns the egress, where round-robin resumes, stall count.
    bit m_busy;
    int m_owner;
    int m_ptr;
    int m_stall;
    bit m_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_busy    = 1'b0;
        m_owner   = 0;
        m_ptr     = 0;
        m_stall   = 0;
        m_timeout = 1'b0;
    endtask

    task automatic push_frame(input int p, input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            sq[p].push_back({(i == n - 1), base + DW'(i)});
        end
    endtask

    task automatic model_update();
        bit nt;
        nt = 1'b0;
        if (reset) begin
            model_clear();
            return;
        end
        if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
                int p;
                p = (m_ptr + k) % N;
                if (req_valid[p]) begin
                    m_owner = p;
                    m_busy  = 1'b1;
                    m_stall = 0;
                    break;
                end
            end
        end else begin
            if (req_valid[m_owner] && egress_ready) begin
                logic [DW:0] b;
                b = sq[m_owner].pop_front();
                if (b[DW]) begin
                    m_busy = 1'b0;
                    m_ptr  = (m_owner + 1) % N;
                end
            end
`ifdef EGRESS_ARB_TIMEOUT_EN
            if (req_valid[m_owner]) begin
                m_stall = 0;
            end else begin
                m_stall++;
                if (m_stall == (1 << TW) - 1) begin
                    nt      = 1'b1;
                    m_busy  = 1'b0;
                    m_ptr   = (m_owner + 1) % N;
                    m_stall = 0;
                end
            end
`endif
        end
        m_timeout = nt;
    endtask

    task automatic drive();
        for (int p = 0; p < N; p++) begin
            if (sq[p].size() > 0 && !mask[p] && (force_v || $urandom_range(3) != 0)) begin
                req_valid[p] = 1'b1;
                req_last[p]  = sq[p][0][DW];
                bus_d[p]     = sq[p][0][DW-1:0];
            end else begin
                req_valid[p] = 1'b0;
                req_last[p]  = 1'($urandom_range(1));
                bus_d[p]     = DW'($urandom);
            end
        end
        egress_ready = erdy_fixed ? erdy_val : ($urandom_range(3) != 0);
    endtask

    task automatic compare();
        logic [N-1:0]  e_rr;
        logic [DW-1:0] e_d;
        logic          e_l;
        logic          e_v;
        e_rr = '0;
        e_d  = '0;
        e_l  = 1'b0;
        e_v  = 1'b0;
        if (m_busy) begin
            e_rr[m_owner] = egress_ready;
            e_d = bus_d[m_owner];
            e_l = req_last[m_owner];
            e_v = req_valid[m_owner];
        end
        chk("busy", busy, m_busy);
        chk("egress_valid", egress_valid, e_v);
        chk("egress_data", egress_data, e_d);
        chk("egress_last", egress_last, e_l);
        chk("req_ready", req_ready, e_rr);
        chk("timeout", timeout, m_timeout);
        if (m_busy) chk("grant_id", grant_id, m_owner);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        drive();
        @(negedge clk);
        compare();
    endtask

    // Entered just after a compare; asserts reset between clock edges.
    task automatic do_reset(input string tag);
        #2 reset = 1'b1;
        #1;
        model_clear();
        for (int p = 0; p < N; p++) sq[p].delete();
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_egress_valid"}, egress_valid, 0);
        step();
        step();
        #2 reset = 1'b0;
    endtask

    initial begin
        for (int p = 0; p < N; p++) bus_d[p] = '0;
        model_clear();
        reset = 1'b1;
        step();
        step();
        chk("rst_busy", busy, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_egress_valid", egress_valid, 0);
        #2 reset = 1'b0;

        // Single requester on port 2, three beats, sink always ready.
        push_frame(2, 3, 20'h002A0);
        step();
        chk("r32_idle_busy", busy, 0);
        step();
        chk("r32_grant", grant_id, 2);
        chk("r32_beat0", egress_data, 20'h002A0);
        step();
        chk("r32_beat1", egress_data, 20'h002A1);
        step();
        chk("r32_beat2", egress_data, 20'h002A2);
        chk("r32_last", egress_last, 1);
        step();
        chk("r32_busy_after", busy, 0);

        // Port 1 with egress_ready 1,0,0,1.
        push_frame(1, 3, 20'h001B0);
        erdy_val = 1'b1; step();
        erdy_val = 1'b1; step();
        chk("r34_grant", grant_id, 1);
        chk("r34_d0", egress_data, 20'h001B0);
        chk("r34_rdy0", req_ready, 4'b0010);
        erdy_val = 1'b0; step();
        chk("r34_d1", egress_data, 20'h001B1);
        chk("r34_rdy1", req_ready, 4'b0000);
        erdy_val = 1'b0; step();
        chk("r34_d2", egress_data, 20'h001B1);
        chk("r34_rdy2", req_ready, 4'b0000);
        chk("r34_valid2", egress_valid, 1);
        erdy_val = 1'b1; step();
        chk("r34_d3", egress_data, 20'h001B1);
        chk("r34_rdy3", req_ready, 4'b0010);
        step();
        chk("r34_d4", egress_data, 20'h001B2);
        step();
        chk("r34_idle", busy, 0);

        // Reset during beat 2 of 4, then fresh arbitration from port 0.
        push_frame(2, 4, 20'h003C0);
        step();
        step();
        step();
        chk("r36_beat2", egress_data, 20'h003C1);
        do_reset("r36");
        push_frame(1, 1, 20'h00410);
        push_frame(0, 1, 20'h00400);
        push_frame(3, 1, 20'h00430);
        step();
        step();
        chk("r36_fresh_grant", grant_id, 0);
        chk("r36_fresh_data", egress_data, 20'h00400);
        repeat (6) step();

        // Ports 0,1,3 with single-beat frames from pointer 0.
        begin : r33
            int got [4];
            int exp33 [4];
            int cnt;
            exp33 = '{0, 1, 3, 0};
            cnt = 0;
            do_reset("r33");
            for (int i = 0; i < 2; i++) begin
                push_frame(0, 1, 20'h00600 + DW'(i));
                push_frame(1, 1, 20'h00610 + DW'(i));
                push_frame(3, 1, 20'h00630 + DW'(i));
            end
            for (int s = 0; s < 24; s++) begin
                step();
                if (busy === 1'b1 && cnt < 4) begin
                    got[cnt] = int'(grant_id);
                    cnt++;
                end
            end
            chk("r33_grants_seen", cnt, 4);
            for (int i = 0; i < cnt; i++) chk("r33_order", got[i], exp33[i]);
        end

`ifdef EGRESS_ARB_TIMEOUT_EN
        // Port 0 goes quiet after its first beat; abort after 7 stall cycles.
        begin : r35
            int k_to;
            k_to = 0;
            do_reset("r35");
            push_frame(0, 3, 20'h00500);
            push_frame(1, 1, 20'h00510);
            step();
            step();
            chk("r35_grant0", grant_id, 0);
            mask[0] = 1'b1;
            for (int k = 1; k <= 12; k++) begin
                step();
                if (timeout === 1'b1) begin
                    k_to = k;
                    break;
                end
            end
            chk("r35_timeout_cycle", k_to, 8);
            step();
            chk("r35_next_grant", grant_id, 1);
            chk("r35_next_busy", busy, 1);
            mask[0] = 1'b0;
            do_reset("r35_end");
        end
`endif

        // Random traffic: random valid gaps, random sink backpressure.
        force_v    = 1'b0;
        erdy_fixed = 1'b0;
        repeat (4000) begin
            for (int p = 0; p < N; p++) begin
                if (sq[p].size() < 3 && $urandom_range(5) == 0) begin
                    push_frame(p, $urandom_range(1, 4), DW'($urandom));
                end
            end
            step();
        end
        force_v    = 1'b1;
        erdy_fixed = 1'b1;
        erdy_val   = 1'b1;
        repeat (100) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
